alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares one 64-bit ALU datapath between two requesters, port 0 and port 1. Typical requesters are the integer pipeline's execute stage and the address-generation/branch unit. Each port uses a valid/ready request handshake, and arbitration is round-robin. The block holds the ALU result in a single output register and tags it with the winning port ID. It instantiates the existing alu internally and is the only driver of its alu_control.

Parameters:
INIT_PRIO, 0, port that holds priority after reset (0 or 1).
WIDTH, 64, operand/result width; fixed at 64 to match alu, and any other value is a synthesis error.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  port 0 request valid.
req0_ready  output  1  port 0 request accepted this cycle when high with req0_valid.
req0_a  input  64  port 0 operand A.
req0_b  input  64  port 0 operand B.
req0_op  input  4  port 0 ALU opcode (alu_control encoding).
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for port 1.
rsp_valid  output  1  result register holds a valid result.
rsp_ready  input  1  consumer takes the result when high with rsp_valid.
rsp_data  output  64  registered ALU result.
rsp_id  output  1  port whose request produced rsp_data.
rsp_zero  output  1  rsp_data == 0; registered alongside rsp_data.
rsp_err  output  1  illegal opcode flag; present only with ALU_ARB_OPCHECK_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_zero=0, rsp_err=0.
  - Priority pointer = INIT_PRIO.
  - req*_ready go low combinationally.
- can_accept = !rsp_valid || rsp_ready. Drain and refill happen in the same cycle, so sustained throughput is 1 op/cycle.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both ports valid: the port named by the priority pointer is granted.
  - Neither valid: no grant.
- reqN_ready = can_accept && grantN. The loser's ready is 0. The ready of the port not granted never depends on its own valid.
- Opcode decode: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 SRA, 0110 SUB, 0111 SLTU, 1000 SLT, 1001 XOR. Opcodes 1010-1111 give result 0.
- Mux to the ALU: the granted port's a/b/op drive the ALU. With no grant, port 0 inputs drive it and the result is discarded.
- Accept (reqN_valid && reqN_ready at edge N):
  - Load rsp_data with the ALU output, rsp_id=N, rsp_zero=(ALU output==0), rsp_valid=1.
  - Latency is exactly 1 cycle: the result is visible after edge N.
- Priority pointer update:
  - Changes only on an accept.
  - Moves to the port that did not win, whether or not that port was requesting.
  - Does not change on cycles with no accept.
- Drain without refill (rsp_valid && rsp_ready && no accept): rsp_valid clears next edge. rsp_data, rsp_id and rsp_zero hold their last values.
- Stall (rsp_valid && !rsp_ready):
  - All outputs hold.
  - Both readys are 0.
  - Requesters must hold valid and payload stable until accepted. A drop before acceptance is a protocol violation.
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on stall, or on accept together with drain.
  - FULL -> EMPTY on drain with no accept.
- Reset mid-operation: a held result is lost and no response is produced for it. Requesters re-issue after reset.
- Width: all arithmetic is 64-bit with wrap-around; no carry/overflow outputs. Shift amounts follow alu (low bits of B).

Optional Feature:
ALU_ARB_OPCHECK_EN:
- Defined:
  - rsp_err port exists.
  - rsp_err is registered with the result: 1 when the accepted opcode is 1010-1111, else 0. rsp_data is still 0 for such opcodes.
  - rsp_err holds with rsp_data during stalls and resets to 0.
- Undefined: no rsp_err port and no check logic; illegal opcodes silently produce 0.

Test Plan:
- Port 0 only, op=0010, a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_zero=0.
- Both ports valid every cycle, INIT_PRIO=0, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; no port waits more than 1 cycle.
- Port 1 op=0110, a=3, b=3 -> rsp_data=0, rsp_zero=1. Then op=1000, a=-1 (all ones), b=1 -> rsp_data=1. Then op=0111 with the same operands -> rsp_data=0.
- Result held with rsp_ready=0 for 3 cycles while both ports are valid -> both readys=0 and rsp outputs stable. Then rsp_ready=1 -> in the same cycle the priority port is accepted and the new result appears next cycle.
- rst_n asserted low while rsp_valid=1 and mid-cycle -> outputs go to 0 immediately without a clock edge. After release, the first contending grant goes to INIT_PRIO.
- With ALU_ARB_OPCHECK_EN, op=1111 -> rsp_data=0, rsp_err=1. Next op=0001, a=8'hF0, b=8'h0F -> rsp_data=8'hFF, rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 64-bit ALU between two valid/ready ports
// Optional macro ALU_ARB_OPCHECK_EN adds the registered rsp_err illegal-opcode flag.
module alu_arbiter #(
    parameter bit INIT_PRIO = 1'b0,
    parameter int WIDTH     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
`ifdef ALU_ARB_OPCHECK_EN
    output logic             rsp_err,
`endif
    output logic             rsp_zero
);
    if (WIDTH != 64) begin : g_width_check
        $error("alu_arbiter: WIDTH must be 64");
    end

    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             zero_q, zero_d;
    logic             can_accept, grant0, grant1, accept;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [3:0]       alu_control;
    logic [5:0]       shamt;

    // Round-robin grant and operand mux; with no grant port 0 drives the ALU and the result is unused
    always_comb begin
        can_accept  = (state_q == EMPTY) || rsp_ready;
        grant1      = req1_valid && (!req0_valid || prio_q);
        grant0      = req0_valid && !grant1;
        accept      = can_accept && (grant0 || grant1);
        alu_a       = grant1 ? req1_a : req0_a;
        alu_b       = grant1 ? req1_b : req0_b;
        alu_control = grant1 ? req1_op : req0_op;
        req0_ready  = rst_n && can_accept && grant0;
        req1_ready  = rst_n && can_accept && grant1;
    end

    // Shared ALU; opcodes 1010-1111 produce zero
    always_comb begin
        shamt = alu_b[5:0];
        case (alu_control)
            4'b0000: alu_y = alu_a & alu_b;
            4'b0001: alu_y = alu_a | alu_b;
            4'b0010: alu_y = alu_a + alu_b;
            4'b0011: alu_y = alu_a << shamt;
            4'b0100: alu_y = alu_a >> shamt;
            4'b0101: alu_y = $signed(alu_a) >>> shamt;
            4'b0110: alu_y = alu_a - alu_b;
            4'b0111: alu_y = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            4'b1000: alu_y = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            4'b1001: alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
        endcase
    end

    // Next state: accept loads the result and hands priority to the other port; drain alone empties
    always_comb begin
        state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
        prio_d  = accept ? !grant1 : prio_q;
        data_d  = accept ? alu_y : data_q;
        id_d    = accept ? grant1 : id_q;
        zero_d  = accept ? (alu_y == '0) : zero_q;
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q, err_d;

    // Illegal-opcode flag travels with the result it belongs to
    always_comb err_d = accept ? (alu_control >= 4'd10) : err_q;

    // Flag register, cleared by reset with the rest of the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign rsp_err = err_q;
`endif

    // Response register, state and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            prio_q  <= INIT_PRIO;
            data_q  <= '0;
            id_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            data_q  <= data_d;
            id_q    <= id_d;
            zero_q  <= zero_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign rsp_zero  = zero_q;
endmodule
